fir_da_sequencer: RTL and testbench

- Control sequencer for the FIR core's bit-serial distributed-arithmetic (DA) datapath, in the clk3 domain.
- Per sample, in order:
  - pops one word from the dcfifo read side;
  - pulses the tap shift-register parallel load;
  - steps the DA unit through DATA_WIDTH bit-serial cycles, flagging the sign-bit cycle for subtraction;
  - waits out the DA pipeline, then presents a sum_valid/sum_ready handshake to the consumer.
- Replaces the free-running 4-bit load counter with a FIFO-aware, back-pressurable scheduler.

---
 rtl/fir_da_sequencer_pkg.sv | 31 +++
 rtl/fir_da_sequencer_if.sv | 33 +++
 rtl/fir_da_sequencer_counter.sv | 36 +++
 rtl/fir_da_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fir_da_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_da_sequencer_pkg.sv
// Shared types, default parameters and timing helpers for the FIR DA sequencer.
// The latency function is the single source of truth for the sum_valid offset.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } fir_seq_state_t;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FIFO_RD_LAT = 1;
  localparam int DEF_DA_LATENCY  = 2;
  localparam int DEF_CNT_WIDTH   = 16;

  // Offset from the pop strobe (cycle 0) to the first cycle with sum_valid high.
  function automatic int fir_sum_latency(input int data_width, input int fifo_rd_lat,
                                         input int da_latency);
    return fifo_rd_lat + 2 + data_width + da_latency;
  endfunction

  // Phase counter must hold DATA_WIDTH-1 as well as the largest legal wait/drain preload (6).
  function automatic int fir_cnt_bits(input int data_width);
    return $clog2((data_width > 8) ? data_width : 8);
  endfunction

endpackage

// File: rtl/fir_da_sequencer_if.sv
// Handshake and strobe bundle between the DA sequencer and the FIFO / DA datapath.
// master = sequencer side, slave = datapath/consumer side.
interface fir_da_sequencer_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

  logic                          enable;
  logic                          fifo_empty;
  logic                          fifo_read;
  logic                          sreg_load;
  logic                          acc_clear;
  logic                          acc_en;
  logic                          msb_sub;
  logic [$clog2(DATA_WIDTH)-1:0] bit_idx;
  logic                          sum_valid;
  logic                          sum_ready;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          sample_count;

  modport master (
    input  enable, fifo_empty, sum_ready,
    output fifo_read, sreg_load, acc_clear, acc_en, msb_sub, bit_idx,
           sum_valid, busy, sample_count
  );

  modport slave (
    output enable, fifo_empty, sum_ready,
    input  fifo_read, sreg_load, acc_clear, acc_en, msb_sub, bit_idx,
           sum_valid, busy, sample_count
  );

endinterface

// File: rtl/fir_da_sequencer_counter.sv
// Loadable down-counter with terminal-count flag, shared by the WAIT, SHIFT and DRAIN phases.
// count_next is exported so the owner can register outputs that depend on the upcoming count.
module fir_seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk3,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count_next,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk3 or negedge areset_n) begin
    if (!areset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/fir_da_sequencer.sv
// FIFO-aware, back-pressurable scheduler for the bit-serial distributed-arithmetic FIR datapath.
// Every output is a register loaded from a decode of the next state.
module fir_da_sequencer import fir_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_RD_LAT = DEF_FIFO_RD_LAT,
  parameter int DA_LATENCY  = DEF_DA_LATENCY,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input logic                clk3,
  input logic                areset_n,
  fir_da_sequencer_if.master bus
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int CW    = fir_cnt_bits(DATA_WIDTH);

  localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] WAIT_INIT  = CW'((FIFO_RD_LAT > 0) ? FIFO_RD_LAT - 1 : 0);
  localparam logic [CW-1:0] DRAIN_INIT = CW'((DA_LATENCY > 0) ? DA_LATENCY - 1 : 0);

  fir_seq_state_t state_reg;
  fir_seq_state_t state_next;

  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_load_val;
  logic [CW-1:0] cnt_next;
  logic          cnt_tc;
  logic [CW-1:0] bit_pos_next;

  logic start_ok;
  logic handshake;

  logic                 fifo_read_reg;
  logic                 sreg_load_reg;
  logic                 acc_clear_reg;
  logic                 acc_en_reg;
  logic                 msb_sub_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic                 sum_valid_reg;
  logic                 busy_reg;
  logic [CNT_WIDTH-1:0] sample_count_reg;

  fir_seq_counter #(
    .WIDTH(CW)
  ) u_phase_cnt (
    .clk3      (clk3),
    .areset_n  (areset_n),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .dec       (cnt_dec),
    .count_next(cnt_next),
    .tc        (cnt_tc)
  );

  // enable and fifo_empty only matter in IDLE and in the DONE handshake cycle.
  assign start_ok  = bus.enable && !bus.fifo_empty;
  assign handshake = (state_reg == ST_DONE) && bus.sum_ready;

  // The counter runs down during SHIFT, so the bit position is its distance from LAST_BIT.
  assign bit_pos_next = LAST_BIT - cnt_next;

  always_ff @(posedge clk3 or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (FIFO_RD_LAT > 0) begin
          state_next   = ST_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = WAIT_INIT;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_tc) begin
          state_next = ST_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        state_next   = ST_SHIFT;
        cnt_load     = 1'b1;
        cnt_load_val = LAST_BIT;
      end
      ST_SHIFT: begin
        if (cnt_tc) begin
          if (DA_LATENCY > 0) begin
            state_next   = ST_DRAIN;
            cnt_load     = 1'b1;
            cnt_load_val = DRAIN_INIT;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_tc) begin
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.sum_ready) begin
          state_next = start_ok ? ST_ISSUE : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk3 or negedge areset_n) begin
    if (!areset_n) begin
      fifo_read_reg    <= 1'b0;
      sreg_load_reg    <= 1'b0;
      acc_clear_reg    <= 1'b0;
      acc_en_reg       <= 1'b0;
      msb_sub_reg      <= 1'b0;
      bit_idx_reg      <= '0;
      sum_valid_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      fifo_read_reg <= (state_next == ST_ISSUE);
      sreg_load_reg <= (state_next == ST_LOAD);
      acc_clear_reg <= (state_next == ST_LOAD);
      acc_en_reg    <= (state_next == ST_SHIFT);
      msb_sub_reg   <= (state_next == ST_SHIFT) && (cnt_next == '0);
      bit_idx_reg   <= (state_next == ST_SHIFT) ? bit_pos_next[BIT_W-1:0] : '0;
      sum_valid_reg <= (state_next == ST_DONE);
      busy_reg      <= (state_next != ST_IDLE);
      if (handshake) begin
        sample_count_reg <= sample_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.fifo_read    = fifo_read_reg;
  assign bus.sreg_load    = sreg_load_reg;
  assign bus.acc_clear    = acc_clear_reg;
  assign bus.acc_en       = acc_en_reg;
  assign bus.msb_sub      = msb_sub_reg;
  assign bus.bit_idx      = bit_idx_reg;
  assign bus.sum_valid    = sum_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.sample_count = sample_count_reg;

endmodule

// File: tb/tb_fir_da_sequencer.sv
// Self-checking bench for fir_da_sequencer: offset-based reference model for the default
// instance plus directed checks on a narrow-counter instance and a zero-latency instance.
module tb_fir_da_sequencer;
  import fir_pkg::*;

  localparam int DW     = 16;
  localparam int RD_A   = 1;
  localparam int LAT_A  = fir_sum_latency(DW, RD_A, 2);
  localparam int LAT_Z  = fir_sum_latency(DW, 0, 0);
  localparam int K_LOAD = RD_A + 1;
  localparam int K_SH0  = RD_A + 2;
  localparam int K_SHN  = RD_A + 1 + DW;

  logic clk3     = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk3 = ~clk3;

  fir_da_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus_a ();
  fir_da_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2))  bus_w ();
  fir_da_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus_z ();

  fir_da_sequencer #(.DATA_WIDTH(DW), .FIFO_RD_LAT(RD_A), .DA_LATENCY(2), .CNT_WIDTH(16))
    dut_a (.clk3(clk3), .areset_n(areset_n), .bus(bus_a));
  fir_da_sequencer #(.DATA_WIDTH(DW), .FIFO_RD_LAT(1), .DA_LATENCY(2), .CNT_WIDTH(2))
    dut_w (.clk3(clk3), .areset_n(areset_n), .bus(bus_w));
  fir_da_sequencer #(.DATA_WIDTH(DW), .FIFO_RD_LAT(0), .DA_LATENCY(0), .CNT_WIDTH(16))
    dut_z (.clk3(clk3), .areset_n(areset_n), .bus(bus_z));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b1;

  always @(posedge clk3) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: k_a is the offset of the current cycle within a sample (-1 = idle).
  int k_a   = -1;
  int cnt_a = 0;
  always @(posedge clk3 or negedge areset_n) begin
    if (!areset_n) begin
      k_a   = -1;
      cnt_a = 0;
    end else if (k_a < 0) begin
      if (bus_a.enable && !bus_a.fifo_empty) k_a = 0;
    end else if (k_a < LAT_A) begin
      k_a++;
    end else if (bus_a.sum_ready) begin
      cnt_a = (cnt_a + 1) % 65536;
      k_a   = (bus_a.enable && !bus_a.fifo_empty) ? 0 : -1;
    end
  end

  always @(negedge clk3) begin
    if (cmp_en) begin
      check("m_fifo_read", bus_a.fifo_read, k_a == 0);
      check("m_sreg_load", bus_a.sreg_load, k_a == K_LOAD);
      check("m_acc_clear", bus_a.acc_clear, k_a == K_LOAD);
      check("m_acc_en",    bus_a.acc_en, (k_a >= K_SH0) && (k_a <= K_SHN));
      check("m_bit_idx",   bus_a.bit_idx, ((k_a >= K_SH0) && (k_a <= K_SHN)) ? k_a - K_SH0 : 0);
      check("m_msb_sub",   bus_a.msb_sub, k_a == K_SHN);
      check("m_sum_valid", bus_a.sum_valid, k_a == LAT_A);
      check("m_busy",      bus_a.busy, k_a >= 0);
      check("m_count",     bus_a.sample_count, cnt_a);
    end
  end

  // Event log for dut_a, used by the hand-computed per-test expectations.
  int rd_q[$];
  int ld_q[$];
  int sv_n, sv_first, acc_n, msb_n, busy_n;

  always @(negedge clk3) begin
    if (bus_a.fifo_read === 1'b1) rd_q.push_back(cyc);
    if (bus_a.sreg_load === 1'b1) ld_q.push_back(cyc);
    if (bus_a.sum_valid === 1'b1) begin
      if (sv_n == 0) sv_first = cyc;
      sv_n++;
    end
    if (bus_a.acc_en === 1'b1)  acc_n++;
    if (bus_a.msb_sub === 1'b1) msb_n++;
    if (bus_a.busy === 1'b1)    busy_n++;
  end

  task automatic clear_log();
    rd_q.delete();
    ld_q.delete();
    sv_n = 0; sv_first = -1000; acc_n = 0; msb_n = 0; busy_n = 0;
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic bit probe(input int sel);
    case (sel)
      0: return bus_a.fifo_read;
      1: return bus_a.sum_valid;
      2: return bus_a.acc_en && (bus_a.bit_idx == 4'd5);
      3: return bus_a.acc_en && (bus_a.bit_idx == 4'd7);
      4: return !bus_a.busy;
      5: return bus_w.sum_valid;
      6: return bus_z.fifo_read;
      7: return bus_z.sum_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name, input int budget);
    int n = 0;
    @(negedge clk3);
    while (!probe(sel) && (n < budget)) begin
      @(negedge clk3);
      n++;
    end
    check({"wait_", name}, probe(sel), 1);
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};
  int rel_cyc;
  int c0;

  initial begin
    bus_a.enable = 1'b0; bus_a.fifo_empty = 1'b1; bus_a.sum_ready = 1'b0;
    bus_w.enable = 1'b0; bus_w.fifo_empty = 1'b1; bus_w.sum_ready = 1'b0;
    bus_z.enable = 1'b0; bus_z.fifo_empty = 1'b1; bus_z.sum_ready = 1'b0;
    clear_log();

    repeat (3) @(negedge clk3);
    check("rst_busy", bus_a.busy, 0);
    check("rst_count", bus_a.sample_count, 0);
    check("rst_sum_valid", bus_a.sum_valid, 0);
    check("rst_fifo_read", bus_a.fifo_read, 0);
    areset_n = 1'b1;

    // Single sample, FIFO becomes non-empty at cycle 5.
    bus_a.enable = 1'b1; bus_a.sum_ready = 1'b1;
    repeat (5) @(negedge clk3);
    clear_log();
    bus_a.fifo_empty = 1'b0;
    wait_for(0, "t1_read", 10);
    bus_a.fifo_empty = 1'b1;
    wait_for(4, "t1_idle", 40);
    check("t1_reads", rd_q.size(), 1);
    check("t1_load_offset", q_at(ld_q, 0) - q_at(rd_q, 0), 2);
    check("t1_valid_offset", sv_first - q_at(rd_q, 0), 21);
    check("t1_valid_cycles", sv_n, 1);
    check("t1_acc_cycles", acc_n, 16);
    check("t1_msb_cycles", msb_n, 1);
    check("t1_count", bus_a.sample_count, 1);

    // Back-to-back, four samples.
    clear_log();
    bus_a.fifo_empty = 1'b0;
    for (int i = 0; i < 4; i++) wait_for(0, "t2_read", 30);
    bus_a.fifo_empty = 1'b1;
    wait_for(4, "t2_idle", 40);
    check("t2_reads", rd_q.size(), 4);
    for (int i = 1; i < 4; i++) check("t2_spacing", q_at(rd_q, i) - q_at(rd_q, i - 1), 22);
    check("t2_busy_cycles", busy_n, 88);
    check("t2_count", bus_a.sample_count, 5);

    // Backpressure: consumer stalls 10 cycles while the FIFO has data.
    clear_log();
    bus_a.sum_ready = 1'b0; bus_a.fifo_empty = 1'b0;
    wait_for(1, "t3_valid", 40);
    repeat (10) @(negedge clk3);
    bus_a.sum_ready = 1'b1; bus_a.fifo_empty = 1'b1;
    @(negedge clk3);
    check("t3_valid_drop", bus_a.sum_valid, 0);
    check("t3_valid_cycles", sv_n, 11);
    check("t3_reads", rd_q.size(), 1);
    check("t3_acc_cycles", acc_n, 16);
    check("t3_count", bus_a.sample_count, 6);

    // Empty FIFO with enable high: nothing starts.
    clear_log();
    repeat (100) @(negedge clk3);
    check("t4_empty_reads", rd_q.size(), 0);
    check("t4_empty_busy", busy_n, 0);

    // enable dropped mid-SHIFT: sample completes, then idle.
    clear_log();
    bus_a.fifo_empty = 1'b0;
    wait_for(2, "t4_bit5", 30);
    bus_a.enable = 1'b0;
    wait_for(1, "t4_valid", 30);
    @(negedge clk3);
    check("t4_busy_after", bus_a.busy, 0);
    check("t4_count", bus_a.sample_count, 7);
    repeat (5) @(negedge clk3);
    check("t4_no_restart", rd_q.size(), 1);

    // Asynchronous reset at bit 7.
    bus_a.enable = 1'b1;
    clear_log();
    wait_for(3, "t5_bit7", 30);
    #2;
    areset_n = 1'b0;
    #1;
    check("t5_async_fifo_read", bus_a.fifo_read, 0);
    check("t5_async_sreg_load", bus_a.sreg_load, 0);
    check("t5_async_acc_clear", bus_a.acc_clear, 0);
    check("t5_async_acc_en", bus_a.acc_en, 0);
    check("t5_async_msb_sub", bus_a.msb_sub, 0);
    check("t5_async_bit_idx", bus_a.bit_idx, 0);
    check("t5_async_sum_valid", bus_a.sum_valid, 0);
    check("t5_async_busy", bus_a.busy, 0);
    check("t5_async_count", bus_a.sample_count, 0);
    repeat (2) @(negedge clk3);
    clear_log();
    areset_n = 1'b1;
    rel_cyc = cyc;
    wait_for(0, "t5_read", 10);
    bus_a.fifo_empty = 1'b1;
    wait_for(4, "t5_idle", 40);
    check("t5_reads", rd_q.size(), 1);
    check("t5_first_read", q_at(rd_q, 0) - rel_cyc, 1);
    check("t5_load_offset", q_at(ld_q, 0) - q_at(rd_q, 0), 2);
    check("t5_valid_offset", sv_first - q_at(rd_q, 0), 21);
    check("t5_acc_cycles", acc_n, 16);
    check("t5_count", bus_a.sample_count, 1);

    // Two-bit sample counter wraps.
    bus_w.sum_ready = 1'b1; bus_w.enable = 1'b1; bus_w.fifo_empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_for(5, "t6_valid", 40);
      if (i == 4) bus_w.fifo_empty = 1'b1;
      @(negedge clk3);
      check("t6_count", bus_w.sample_count, wrap_exp[i]);
    end

    // Zero FIFO latency, zero DA latency.
    bus_z.sum_ready = 1'b1; bus_z.enable = 1'b1; bus_z.fifo_empty = 1'b0;
    wait_for(6, "t7_read", 10);
    c0 = cyc;
    bus_z.fifo_empty = 1'b1;
    @(negedge clk3);
    check("t7_load_next", bus_z.sreg_load, 1);
    wait_for(7, "t7_valid", 40);
    check("t7_latency", cyc - c0, 18);
    check("t7_latency_fn", cyc - c0, LAT_Z);
    @(negedge clk3);
    check("t7_count", bus_z.sample_count, 1);
    check("t7_idle", bus_z.busy, 0);

    repeat (2) @(negedge clk3);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
